// File: rtl/set_assoc_cache_if.sv
// set_assoc_cache_if
//  Groups the CPU request/response handshake and the word-wide memory beat bus
//  of the set-associative cache.
//  Modports:
//   slave  - cache view: takes requests and drives memory beats.
//   master - CPU/memory view: issues requests and acknowledges beats.
//  Signals:
//   req_valid/req_write/req_funct/req_addr/req_wdata  CPU request (to cache)
//   req_ready                                         cache idle (from cache)
//   resp_valid/resp_hit/resp_rdata                    completion pulse and load data
//   mem_req/mem_write/mem_addr/mem_wdata              memory beat request (from cache)
//   mem_rdata/mem_done                                fill data and beat acknowledge
interface set_assoc_cache_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_write;
  logic [2:0]        req_funct;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_hit;
  logic [31:0]       resp_rdata;
  logic              mem_req;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;

  modport slave (
    input  req_valid, req_write, req_funct, req_addr, req_wdata,
    output req_ready, resp_valid, resp_hit, resp_rdata,
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport master (
    output req_valid, req_write, req_funct, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_hit, resp_rdata,
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/set_assoc_cache.sv
// set_assoc_cache
//  2-way set-associative, write-back / write-allocate data cache between the CPU
//  load/store port and word-wide main memory. Supports lw/sw, lb/sb and lbu.
//  Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - set_assoc_cache_if.slave: CPU request/response and memory beat bus
module set_assoc_cache #(
  parameter int ADDR_W = 10,
  parameter int SETS   = 2,
  parameter int WORDS  = 4
) (
  input logic              clk,
  input logic              rst_n,
  set_assoc_cache_if.slave bus
);
  localparam int OFF_W  = $clog2(WORDS) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BEAT_W = $clog2(WORDS);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          funct_q;
  logic [31:0]         wdata_q;
  logic                write_q;
  logic                victim_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                req_ready_q, resp_valid_q, resp_hit_q;
  logic [31:0]         resp_rdata_q;
  logic                mem_req_q, mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic [SETS-1:0][1:0] valid_q, dirty_q;
  logic [SETS-1:0]     lru_q;           // way to evict next in each set

  logic [TAG_W-1:0]    tag_mem  [SETS][2];
  logic [31:0]         data_mem [SETS][2][WORDS];

  // Load formatting: lb sign-extends, lbu zero-extends, everything else is a word.
  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f,
                                           input logic [1:0] b);
    logic [7:0] by;
    by = w[{b, 3'b000} +: 8];
    case (f)
      3'b000:  return {{24{by[7]}}, by};
      3'b100:  return {24'd0, by};
      default: return w;
    endcase
  endfunction

  // Store merge: byte stores replace only the addressed byte.
  function automatic logic [31:0] store_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                              input logic [2:0] f, input logic [1:0] b);
    logic [31:0] res;
    res = wd;
    if (f == 3'b000 || f == 3'b100) begin
      res = old_w;
      res[{b, 3'b000} +: 8] = wd[7:0];
    end
    return res;
  endfunction

  logic [TAG_W-1:0]  req_tag, victim_tag, beat_tag;
  logic [IDX_W-1:0]  req_set;
  logic [BEAT_W-1:0] req_word;
  logic              hit0, hit1, hit, hit_way, lru_way, last_beat;
  logic [31:0]       lookup_word, resp_word, beat_wdata;
  logic [ADDR_W-1:0] beat_addr;

  assign req_tag     = addr_q[ADDR_W-1 -: TAG_W];
  assign req_set     = addr_q[OFF_W +: IDX_W];
  assign req_word    = addr_q[OFF_W-1:2];
  assign hit0        = valid_q[req_set][0] && (tag_mem[req_set][0] == req_tag);
  assign hit1        = valid_q[req_set][1] && (tag_mem[req_set][1] == req_tag);
  assign hit         = hit0 || hit1;
  assign hit_way     = !hit0;           // way 0 wins if both match
  assign lru_way     = lru_q[req_set];
  assign lookup_word = data_mem[req_set][hit_way][req_word];
  assign resp_word   = data_mem[req_set][victim_q][req_word];
  assign victim_tag  = tag_mem[req_set][victim_q];
  assign beat_tag    = (state_q == S_WB) ? victim_tag : req_tag;
  assign beat_addr   = {beat_tag, req_set, beat_q, 2'b00};
  assign beat_wdata  = data_mem[req_set][victim_q][beat_q];
  assign last_beat   = (beat_q == BEAT_W'(WORDS - 1));

  // Single data-array write port; the three writers live in disjoint states.
  logic              dwe, dway;
  logic [BEAT_W-1:0] dword;
  logic [31:0]       dval;

  always_comb begin
    dwe   = 1'b0;
    dway  = victim_q;
    dword = beat_q;
    dval  = bus.mem_rdata;
    case (state_q)
      S_LOOKUP: if (hit && write_q) begin
        dwe   = 1'b1;
        dway  = hit_way;
        dword = req_word;
        dval  = store_merge(lookup_word, wdata_q, funct_q, addr_q[1:0]);
      end
      S_FILL:   dwe = mem_req_q && bus.mem_done;
      S_RESP:   if (write_q) begin
        dwe   = 1'b1;
        dword = req_word;
        dval  = store_merge(resp_word, wdata_q, funct_q, addr_q[1:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (dwe) data_mem[req_set][dway][dword] <= dval;
    if (state_q == S_RESP) tag_mem[req_set][victim_q] <= req_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      funct_q      <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      victim_q     <= 1'b0;
      beat_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.req_valid) begin
          addr_q      <= bus.req_addr;
          funct_q     <= bus.req_funct;
          wdata_q     <= bus.req_wdata;
          write_q     <= bus.req_write;
          req_ready_q <= 1'b0;
          state_q     <= S_LOOKUP;
        end
        S_LOOKUP: if (hit) begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= 1'b1;
          resp_rdata_q <= write_q ? 32'd0 : load_fmt(lookup_word, funct_q, addr_q[1:0]);
          if (write_q) dirty_q[req_set][hit_way] <= 1'b1;
          lru_q[req_set] <= !hit_way;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end else begin
          victim_q <= lru_way;
          beat_q   <= '0;
          state_q  <= (valid_q[req_set][lru_way] && dirty_q[req_set][lru_way]) ? S_WB : S_FILL;
        end
        S_WB, S_FILL: begin
          // A beat is issued only from mem_req=0, which guarantees the idle
          // cycle between beats and keeps addr/wdata frozen while mem_req=1.
          if (!mem_req_q) begin
            mem_req_q   <= 1'b1;
            mem_write_q <= (state_q == S_WB);
            mem_addr_q  <= beat_addr;
            mem_wdata_q <= (state_q == S_WB) ? beat_wdata : 32'd0;
          end else if (bus.mem_done) begin
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            beat_q      <= beat_q + 1'b1;
            if (last_beat) state_q <= (state_q == S_WB) ? S_FILL : S_RESP;
          end
        end
        S_RESP: begin
          valid_q[req_set][victim_q] <= 1'b1;
          dirty_q[req_set][victim_q] <= write_q;
          lru_q[req_set]             <= !victim_q;
          resp_valid_q <= 1'b1;
          resp_hit_q   <= 1'b0;
          resp_rdata_q <= write_q ? 32'd0 : load_fmt(resp_word, funct_q, addr_q[1:0]);
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache
//  Directed bench for set_assoc_cache (ADDR_W=10, SETS=2, WORDS=4) with a
//  word-wide memory model that logs every beat it acknowledges.
module tb_set_assoc_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  set_assoc_cache_if #(.ADDR_W(10)) bus ();
  set_assoc_cache #(.ADDR_W(10), .SETS(2), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem [256];
  logic        mem_stall = 1'b0;
  logic [9:0]  log_addr [128];
  logic        log_wr   [128];
  logic [31:0] log_data [128];
  int          log_n = 0;

  // Memory model: one-cycle mem_done pulse one negedge after a request is seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.mem_done = 1'b0;
    end else if (bus.mem_done) begin
      bus.mem_done = 1'b0;
    end else if (bus.mem_req && !mem_stall) begin
      bus.mem_done = 1'b1;
      if (bus.mem_write) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
      else bus.mem_rdata = mem[bus.mem_addr[9:2]];
      log_addr[log_n] = bus.mem_addr;
      log_wr[log_n]   = bus.mem_write;
      log_data[log_n] = bus.mem_write ? bus.mem_wdata : mem[bus.mem_addr[9:2]];
      log_n++;
    end
  end

  task automatic do_req(input logic wr, input logic [2:0] f, input logic [9:0] a,
                        input logic [31:0] wd, output logic hit, output logic [31:0] rd,
                        output int cyc, output int beats);
    int ls;
    ls = log_n;
    cyc = 0;
    hit = 1'bx;
    rd = 'x;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_funct = f;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.resp_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (bus.resp_valid) begin
      hit = bus.resp_hit;
      rd  = bus.resp_rdata;
    end else begin
      cyc = -1;
    end
    beats = log_n - ls;
    $display("txn %s f=%b addr=%h wdata=%h -> hit=%b rdata=%h cycles=%0d beats=%0d",
             wr ? "ST" : "LD", f, a, wd, hit, rd, cyc, beats);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_hit, bus.mem_req, bus.mem_write} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=10000",
               {bus.req_ready, bus.resp_valid, bus.resp_hit, bus.mem_req, bus.mem_write});
    end
    n_cmp++;
    if ({bus.resp_rdata, bus.mem_addr, bus.mem_wdata} !== 74'd0) begin
      n_fail++;
      $display("FAIL reset_data rdata=%h maddr=%h mwdata=%h exp=0", bus.resp_rdata, bus.mem_addr, bus.mem_wdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss();
    logic h; logic [31:0] r; int c, b;
    do_req(1'b0, 3'b010, 10'h040, 32'd0, h, r, c, b);
    n_cmp++; if (h !== 1'b0 || r !== 32'd1) begin n_fail++; $display("FAIL cold_resp hit=%b rdata=%h exp hit=0 rdata=00000001", h, r); end
    n_cmp++; if (b !== 4) begin n_fail++; $display("FAIL cold_beats got=%0d exp=4", b); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (log_addr[log_n-4+k] !== 10'(10'h040 + 4*k) || log_wr[log_n-4+k] !== 1'b0) begin
        n_fail++;
        $display("FAIL cold_beat%0d addr=%h wr=%b exp addr=%h wr=0", k, log_addr[log_n-4+k], log_wr[log_n-4+k], 10'(10'h040 + 4*k));
      end
    end
  endtask

  task automatic test_hit();
    logic h; logic [31:0] r; int c, b;
    do_req(1'b0, 3'b010, 10'h048, 32'd0, h, r, c, b);
    n_cmp++; if (h !== 1'b1 || r !== 32'd3) begin n_fail++; $display("FAIL hit_resp hit=%b rdata=%h exp hit=1 rdata=00000003", h, r); end
    n_cmp++; if (c !== 2) begin n_fail++; $display("FAIL hit_latency got=%0d exp=2", c); end
    n_cmp++; if (b !== 0) begin n_fail++; $display("FAIL hit_no_mem beats=%0d exp=0", b); end
  endtask

  task automatic test_byte_ops();
    logic h; logic [31:0] r; int c, b;
    do_req(1'b1, 3'b000, 10'h041, 32'h0000_0080, h, r, c, b);
    n_cmp++; if (h !== 1'b1 || r !== 32'd0) begin n_fail++; $display("FAIL sb_resp hit=%b rdata=%h exp hit=1 rdata=0", h, r); end
    do_req(1'b0, 3'b000, 10'h041, 32'd0, h, r, c, b);
    n_cmp++; if (h !== 1'b1 || r !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_resp hit=%b rdata=%h exp hit=1 rdata=ffffff80", h, r); end
    do_req(1'b0, 3'b100, 10'h041, 32'd0, h, r, c, b);
    n_cmp++; if (h !== 1'b1 || r !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_resp hit=%b rdata=%h exp hit=1 rdata=00000080", h, r); end
    do_req(1'b0, 3'b010, 10'h040, 32'd0, h, r, c, b);
    n_cmp++; if (r !== 32'h0000_8001) begin n_fail++; $display("FAIL sb_merge rdata=%h exp=00008001", r); end
  endtask

  task automatic test_writeback();
    logic h; logic [31:0] r; int c, b;
    logic [31:0] wb_exp [4];
    wb_exp[0] = 32'h0000_8001; wb_exp[1] = 32'd2; wb_exp[2] = 32'd3; wb_exp[3] = 32'd4;
    // 0x000 takes the empty way; 0x080 then evicts the dirty 0x040 block.
    do_req(1'b0, 3'b010, 10'h000, 32'd0, h, r, c, b);
    n_cmp++; if (h !== 1'b0 || r !== 32'h1000_0000 || b !== 4) begin n_fail++; $display("FAIL fill000 hit=%b rdata=%h beats=%0d exp 0/10000000/4", h, r, b); end
    do_req(1'b0, 3'b010, 10'h080, 32'd0, h, r, c, b);
    n_cmp++; if (h !== 1'b0 || r !== 32'h1000_0020 || b !== 8) begin n_fail++; $display("FAIL fill080 hit=%b rdata=%h beats=%0d exp 0/10000020/8", h, r, b); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (log_addr[log_n-8+k] !== 10'(10'h040 + 4*k) || log_wr[log_n-8+k] !== 1'b1 || log_data[log_n-8+k] !== wb_exp[k]) begin
        n_fail++;
        $display("FAIL wb_beat%0d addr=%h wr=%b data=%h exp addr=%h wr=1 data=%h", k,
                 log_addr[log_n-8+k], log_wr[log_n-8+k], log_data[log_n-8+k], 10'(10'h040 + 4*k), wb_exp[k]);
      end
      n_cmp++;
      if (log_addr[log_n-4+k] !== 10'(10'h080 + 4*k) || log_wr[log_n-4+k] !== 1'b0) begin
        n_fail++;
        $display("FAIL wb_fill%0d addr=%h wr=%b exp addr=%h wr=0", k, log_addr[log_n-4+k], log_wr[log_n-4+k], 10'(10'h080 + 4*k));
      end
    end
    // 0x100 now evicts the clean 0x000 block: fill only.
    do_req(1'b0, 3'b010, 10'h100, 32'd0, h, r, c, b);
    n_cmp++; if (h !== 1'b0 || r !== 32'h1000_0040 || b !== 4) begin n_fail++; $display("FAIL fill100 hit=%b rdata=%h beats=%0d exp 0/10000040/4", h, r, b); end
  endtask

  task automatic test_reset_mid_fill();
    logic h; logic [31:0] r; int c, b, ls, k;
    ls = log_n;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct = 3'b010;
    bus.req_addr = 10'h180; bus.req_wdata = 32'd0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    k = 0;
    while (!(log_n - ls >= 2 && bus.mem_req) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++; if (k >= 100) begin n_fail++; $display("FAIL rst_reach_beat2 timeout beats=%0d exp>=2", log_n - ls); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_abort mem_req=%b req_ready=%b exp 0/1", bus.mem_req, bus.req_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 3'b010, 10'h100, 32'd0, h, r, c, b);
    n_cmp++; if (h !== 1'b0 || r !== 32'h1000_0040 || b !== 4) begin n_fail++; $display("FAIL rst_remiss hit=%b rdata=%h beats=%0d exp 0/10000040/4", h, r, b); end
  endtask

  task automatic test_wb_stall();
    logic h; logic [31:0] r; int c, b, k, ls;
    do_req(1'b1, 3'b010, 10'h100, 32'h1234_5678, h, r, c, b);
    n_cmp++; if (h !== 1'b1 || b !== 0) begin n_fail++; $display("FAIL stall_sw hit=%b beats=%0d exp 1/0", h, b); end
    do_req(1'b0, 3'b010, 10'h200, 32'd0, h, r, c, b);
    n_cmp++; if (h !== 1'b0 || r !== 32'h1000_0080 || b !== 4) begin n_fail++; $display("FAIL stall_fill200 hit=%b rdata=%h beats=%0d exp 0/10000080/4", h, r, b); end
    mem_stall = 1'b1;
    ls = log_n;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct = 3'b010;
    bus.req_addr = 10'h300; bus.req_wdata = 32'd0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.mem_req && k < 50) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if ({bus.mem_req, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 10'h100, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL stall_first_wb req=%b wr=%b addr=%h data=%h exp 1/1/100/12345678", bus.mem_req, bus.mem_write, bus.mem_addr, bus.mem_wdata);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.req_ready} !== {1'b1, 10'h100, 32'h1234_5678, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d req=%b addr=%h data=%h ready=%b exp 1/100/12345678/0", i, bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.req_ready);
      end
    end
    mem_stall = 1'b0;
    k = 0;
    while (!bus.resp_valid && k < 200) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if (!bus.resp_valid || bus.resp_hit !== 1'b0 || bus.resp_rdata !== 32'h1000_00C0 || log_n - ls !== 8) begin
      n_fail++;
      $display("FAIL stall_resp valid=%b hit=%b rdata=%h beats=%0d exp 1/0/100000c0/8", bus.resp_valid, bus.resp_hit, bus.resp_rdata, log_n - ls);
    end
    $display("txn LD f=010 addr=300 (stalled WB) -> hit=%b rdata=%h beats=%0d", bus.resp_hit, bus.resp_rdata, log_n - ls);
    n_cmp++; if (mem[64] !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_wb_mem got=%h exp=12345678", mem[64]); end
  endtask

  initial begin
    for (int w = 0; w < 256; w++) mem[w] = 32'h1000_0000 + w;
    mem[16] = 32'd1; mem[17] = 32'd2; mem[18] = 32'd3; mem[19] = 32'd4;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct = 3'b010;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_rdata = '0; bus.mem_done = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_byte_ops();
    test_writeback();
    n_cmp++; if (mem[16] !== 32'h0000_8001) begin n_fail++; $display("FAIL wb_mem_word0 got=%h exp=00008001", mem[16]); end
    test_reset_mid_fill();
    test_wb_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
